// File: rtl/fourbit_fa_str.sv
// fourbit_fa_str: registered 4-bit gate-level ripple-carry adder; define FOURBIT_FA_STR_OVF_EN to add the V overflow output
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p, g, t;
  xor (p, a, b);
  xor (s, p, ci);
  and (g, a, b);
  and (t, ci, p);
  or  (co, g, t);
endmodule

module fourbit_fa_str (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
`ifdef FOURBIT_FA_STR_OVF_EN
  ,
  output logic       V
`endif
);
  logic [4:0] c;
  logic [3:0] s_c;
  assign c[0] = Cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    fa_cell u_fa (.a(A[i]), .b(B[i]), .ci(c[i]), .s(s_c[i]), .co(c[i+1]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      S    <= 4'b0000;
      Cout <= 1'b0;
`ifdef FOURBIT_FA_STR_OVF_EN
      V    <= 1'b0;
`endif
    end else begin
      S    <= s_c;
      Cout <= c[4];
`ifdef FOURBIT_FA_STR_OVF_EN
      V    <= c[3] ^ c[4];
`endif
    end
  end
endmodule

// File: tb/tb_fourbit_fa_str.sv
// tb_fourbit_fa_str: directed, exhaustive and random checks of fourbit_fa_str against an arithmetic model
module tb_fourbit_fa_str;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic Cin = 1'b0;
  logic [3:0] S;
  logic Cout;
  int errors = 0;
  int checks = 0;
`ifdef FOURBIT_FA_STR_OVF_EN
  logic V;
  fourbit_fa_str dut (.clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout), .V(V));
`else
  fourbit_fa_str dut (.clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout));
`endif

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int t;
    t = int'(a) + int'(b) + int'(ci);
    return t[4:0];
  endfunction

  function automatic logic ref_ovf(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int sa, sb, t;
    sa = (a > 7) ? int'(a) - 16 : int'(a);
    sb = (b > 7) ? int'(b) - 16 : int'(b);
    t = sa + sb + int'(ci);
    return (t > 7) || (t < -8);
  endfunction

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic r);
    A = a;
    B = b;
    Cin = ci;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] es, input logic ec, input logic ev);
    checks++;
    assert ({Cout, S} === {ec, es}) else begin
      errors++;
      $error("FAIL %s: got Cout=%0b S=%0d, want Cout=%0b S=%0d", tag, Cout, S, ec, es);
    end
`ifdef FOURBIT_FA_STR_OVF_EN
    checks++;
    assert (V === ev) else begin
      errors++;
      $error("FAIL %s V: got %0b, want %0b", tag, V, ev);
    end
`else
    if (ev !== ev) $display("unreachable");
`endif
  endtask

  task automatic op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] e;
    e = ref_sum(a, b, ci);
    apply(a, b, ci, 1'b0);
    check(tag, e[3:0], e[4], ref_ovf(a, b, ci));
  endtask

  initial begin
    logic [4:0] e;
    logic [3:0] ra, rb;
    logic rc;
    apply(4'd13, 4'd11, 1'b1, 1'b1);
    check("reset", 4'd0, 1'b0, 1'b0);
    op("cin_only", 4'd0, 4'd0, 1'b1);
    op("zero", 4'd0, 4'd0, 1'b0);
    op("wrap15_1", 4'd15, 4'd1, 1'b0);
    op("max", 4'd15, 4'd15, 1'b1);
    op("ovf_7_1", 4'd7, 4'd1, 1'b0);
    op("ovf_8_8", 4'd8, 4'd8, 1'b0);
    op("no_ovf_3_2", 4'd3, 4'd2, 1'b0);
    apply(4'd9, 4'd9, 1'b0, 1'b1);
    check("rst_priority", 4'd0, 1'b0, 1'b0);
    apply(4'd9, 4'd9, 1'b0, 1'b0);
    check("post_rst", 4'd2, 1'b1, 1'b1);
    // inputs changed between edges must not disturb the registered outputs
    A = 4'd1;
    B = 4'd2;
    Cin = 1'b1;
    rst = 1'b1;
    #3;
    check("hold", 4'd2, 1'b1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 512; i++) begin
      ra = 4'(i >> 5);
      rb = 4'(i >> 1);
      rc = i[0];
      op("sweep", ra, rb, rc);
    end
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        apply(ra, rb, rc, 1'b1);
        check("rand_rst", 4'd0, 1'b0, 1'b0);
      end else begin
        e = ref_sum(ra, rb, rc);
        apply(ra, rb, rc, 1'b0);
        check("rand", e[3:0], e[4], ref_ovf(ra, rb, rc));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
